xnor_bist_ctrl: RTL and testbench

Built-in self-test sequencer for one 2-input XNOR gate instance (ports a, b, y).
- On start, drives all four input vectors into the gate and waits a settle window.
- Samples y, compares it with the expected XNOR value and counts mismatches.
- Reports busy/done/pass to the bring-up controller, which uses it before enabling the gate datapath.

---
 rtl/xnor_bist_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_xnor_bist_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_bist_ctrl.sv
// xnor_bist_ctrl: built-in self-test sequencer for one 2-input XNOR gate.
// Drives all four (a,b) vectors, waits a settle window, samples y and
// counts mismatches against the expected XNOR value.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_start       run request, sampled only while idle
//   i_abort       ends a run immediately, no done pulse
//   o_gate_a/b    registered drive to the gate inputs
//   i_gate_y      gate output under test
//   o_busy        high while a vector is being applied/settled/checked
//   o_done        one-cycle pulse when a run completes
//   o_pass        last completed run saw zero mismatches
//   o_err_count   saturating mismatch count of the current/last run
//
// Optional feature (macro XNOR_BIST_FIRST_FAIL_EN): adds o_fail_valid,
// o_fail_idx, o_fail_y and o_fail_loop, capturing the first mismatch of
// a run. With the macro undefined those ports and registers do not exist.

module xnor_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_gate_a,
    output logic             o_gate_b,
    input  logic             i_gate_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count
`ifdef XNOR_BIST_FIRST_FAIL_EN
    ,
    output logic             o_fail_valid,
    output logic [1:0]       o_fail_idx,
    output logic             o_fail_y,
    output logic [7:0]       o_fail_loop
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // WAIT is entered with SETTLE_CYCLES-1 and leaves when the counter
    // reads zero, giving exactly SETTLE_CYCLES cycles in WAIT.
    localparam logic [7:0] SETTLE_INIT =
        8'((SETTLE_CYCLES == 0) ? 0 : (SETTLE_CYCLES - 1));
    localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [7:0]       r_loop;
    logic [7:0]       r_settle;
    logic             r_gate_a;
    logic             r_gate_b;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;

    state_t           w_state_nxt;
    logic [1:0]       w_idx_nxt;
    logic [7:0]       w_loop_nxt;
    logic [7:0]       w_settle_nxt;
    logic             w_gate_a_nxt;
    logic             w_gate_b_nxt;
    logic             w_pass_nxt;
    logic [ERR_W-1:0] w_err_nxt;

    logic             w_expect;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_sat;
    logic [ERR_W-1:0] w_err_chk;
    logic [1:0]       w_idx_inc;
    logic             w_start_acc;
    logic             w_check_fail;

    assign w_expect   = ~(r_gate_a ^ r_gate_b);
    assign w_mismatch = (i_gate_y != w_expect);
    assign w_err_sat  = (r_err == ERR_MAX) ? r_err
                                           : r_err + 1'b1;
    // Error count including the vector being checked this cycle.
    assign w_err_chk  = w_mismatch ? w_err_sat : r_err;
    assign w_idx_inc  = r_idx + 2'd1;

    assign w_start_acc  = (r_state == S_IDLE) && i_start
                          && !i_abort;
    assign w_check_fail = (r_state == S_CHECK) && w_mismatch
                          && !i_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_loop   <= 8'd0;
            r_settle <= 8'd0;
            r_gate_a <= 1'b0;
            r_gate_b <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_loop   <= w_loop_nxt;
            r_settle <= w_settle_nxt;
            r_gate_a <= w_gate_a_nxt;
            r_gate_b <= w_gate_b_nxt;
            r_pass   <= w_pass_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Gate drives are loaded on entry to APPLY so each vector is held
    // through APPLY, WAIT and CHECK.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_loop_nxt   = r_loop;
        w_settle_nxt = r_settle;
        w_gate_a_nxt = r_gate_a;
        w_gate_b_nxt = r_gate_b;
        w_pass_nxt   = r_pass;
        w_err_nxt    = r_err;

        case (r_state)
            S_IDLE: begin
                w_gate_a_nxt = 1'b0;
                w_gate_b_nxt = 1'b0;
                if (w_start_acc) begin
                    w_state_nxt = S_APPLY;
                    w_err_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                    w_idx_nxt   = 2'd0;
                    w_loop_nxt  = 8'd0;
                end
            end
            S_APPLY: begin
                if (SETTLE_CYCLES == 0) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt  = S_WAIT;
                    w_settle_nxt = SETTLE_INIT;
                end
            end
            S_WAIT: begin
                if (r_settle == 8'd0) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_settle_nxt = r_settle - 8'd1;
                end
            end
            S_CHECK: begin
                w_err_nxt = w_err_chk;
                if (r_idx != 2'd3) begin
                    w_idx_nxt    = w_idx_inc;
                    w_gate_a_nxt = w_idx_inc[1];
                    w_gate_b_nxt = w_idx_inc[0];
                    w_state_nxt  = S_APPLY;
                end else if (r_loop != LOOP_LAST) begin
                    w_idx_nxt    = 2'd0;
                    w_loop_nxt   = r_loop + 8'd1;
                    w_gate_a_nxt = 1'b0;
                    w_gate_b_nxt = 1'b0;
                    w_state_nxt  = S_APPLY;
                end else begin
                    w_pass_nxt  = (w_err_chk == '0);
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_gate_a_nxt = 1'b0;
                w_gate_b_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_gate_a_nxt = 1'b0;
                w_gate_b_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase

        // Abort wins over every transition; the partial error count is
        // kept so the controller can inspect it.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_nxt  = S_IDLE;
            w_gate_a_nxt = 1'b0;
            w_gate_b_nxt = 1'b0;
            w_pass_nxt   = 1'b0;
            w_err_nxt    = r_err;
            w_settle_nxt = 8'd0;
        end
    end

    assign o_gate_a    = r_gate_a;
    assign o_gate_b    = r_gate_b;
    assign o_busy      = (r_state == S_APPLY)
                      || (r_state == S_WAIT)
                      || (r_state == S_CHECK);
    assign o_done      = (r_state == S_DONE);
    assign o_pass      = r_pass;
    assign o_err_count = r_err;

`ifdef XNOR_BIST_FIRST_FAIL_EN
    logic       r_fail_valid;
    logic [1:0] r_fail_idx;
    logic       r_fail_y;
    logic [7:0] r_fail_loop;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_acc) begin
            r_fail_valid <= 1'b0;
            r_fail_idx   <= 2'd0;
            r_fail_y     <= 1'b0;
            r_fail_loop  <= 8'd0;
        end else if (w_check_fail && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_idx   <= r_idx;
            r_fail_y     <= i_gate_y;
            r_fail_loop  <= r_loop;
        end
    end

    assign o_fail_valid = r_fail_valid;
    assign o_fail_idx   = r_fail_idx;
    assign o_fail_y     = r_fail_y;
    assign o_fail_loop  = r_fail_loop;
`else
    logic w_unused;
    assign w_unused = w_check_fail;
`endif

endmodule

// File: tb/tb_xnor_bist_ctrl.sv
// tb_xnor_bist_ctrl: scoreboard bench for xnor_bist_ctrl.
// Three instances: defaults, LOOPS=3/SETTLE=0, and the same with ERR_W=3.

module tb_xnor_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:1] start = '0;
    logic       abort = 1'b0;
    int         mode = 0;  // 0 xnor, 1 stuck-at-0, 2 xor

    logic       a1, b1, y1, busy1, done1, pass1;
    logic [7:0] err1;
    logic       a2, b2, y2, busy2, done2, pass2;
    logic [7:0] err2;
    logic       a3, b3, y3, busy3, done3, pass3;
    logic [2:0] err3;
`ifdef XNOR_BIST_FIRST_FAIL_EN
    logic       fv1, fy1, fv2, fy2, fv3, fy3;
    logic [1:0] fi1, fi2, fi3;
    logic [7:0] fl1, fl2, fl3;
`endif

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int inst;
        int err;
        bit pass;
        int busy;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic model_y(int m, logic a, logic b);
        if (m == 0) return ~(a ^ b);
        if (m == 1) return 1'b0;
        return a ^ b;
    endfunction

    assign y1 = model_y(mode, a1, b1);
    assign y2 = model_y(mode, a2, b2);
    assign y3 = model_y(mode, a3, b3);

    xnor_bist_ctrl u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]),
        .i_abort(abort), .o_gate_a(a1), .o_gate_b(b1),
        .i_gate_y(y1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_err_count(err1)
`ifdef XNOR_BIST_FIRST_FAIL_EN
        , .o_fail_valid(fv1), .o_fail_idx(fi1),
        .o_fail_y(fy1), .o_fail_loop(fl1)
`endif
    );

    xnor_bist_ctrl #(
        .SETTLE_CYCLES(0), .LOOPS(3), .ERR_W(8)
    ) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]),
        .i_abort(1'b0), .o_gate_a(a2), .o_gate_b(b2),
        .i_gate_y(y2), .o_busy(busy2), .o_done(done2),
        .o_pass(pass2), .o_err_count(err2)
`ifdef XNOR_BIST_FIRST_FAIL_EN
        , .o_fail_valid(fv2), .o_fail_idx(fi2),
        .o_fail_y(fy2), .o_fail_loop(fl2)
`endif
    );

    xnor_bist_ctrl #(
        .SETTLE_CYCLES(0), .LOOPS(3), .ERR_W(3)
    ) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start[3]),
        .i_abort(1'b0), .o_gate_a(a3), .o_gate_b(b3),
        .i_gate_y(y3), .o_busy(busy3), .o_done(done3),
        .o_pass(pass3), .o_err_count(err3)
`ifdef XNOR_BIST_FIRST_FAIL_EN
        , .o_fail_valid(fv3), .o_fail_idx(fi3),
        .o_fail_y(fy3), .o_fail_loop(fl3)
`endif
    );

    function automatic logic sel_busy(int i);
        if (i == 1) return busy1;
        if (i == 2) return busy2;
        return busy3;
    endfunction

    function automatic logic sel_done(int i);
        if (i == 1) return done1;
        if (i == 2) return done2;
        return done3;
    endfunction

    function automatic logic sel_pass(int i);
        if (i == 1) return pass1;
        if (i == 2) return pass2;
        return pass3;
    endfunction

    function automatic int sel_err(int i);
        if (i == 1) return int'(err1);
        if (i == 2) return int'(err2);
        return int'(err3);
    endfunction

    function automatic logic [1:0] sel_gates(int i);
        if (i == 1) return {a1, b1};
        if (i == 2) return {a2, b2};
        return {a3, b3};
    endfunction

    // Reference: mismatches per pass times loops, saturated.
    function automatic exp_t make_exp(int i, int m);
        exp_t e;
        int loops, settle, emax, cnt;
        logic [1:0] v;
        loops  = (i == 1) ? 1 : 3;
        settle = (i == 1) ? 2 : 0;
        emax   = (i == 3) ? 7 : 255;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            if (model_y(m, v[1], v[0]) !== ~(v[1] ^ v[0]))
                cnt++;
        end
        cnt = cnt * loops;
        if (cnt > emax) cnt = emax;
        e.inst = i;
        e.err  = cnt;
        e.pass = (cnt == 0);
        e.busy = loops * 4 * (settle + 2);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered on the first busy cycle; runs to DONE and scores it.
    task automatic wait_done(input int i);
        int n, per;
        bit gok;
        exp_t e;
        logic [1:0] v;
        per = (i == 1) ? 4 : 2;
        n = 0;
        gok = 1;
        while (sel_busy(i) === 1'b1 && n < 400) begin
            v = 2'((n / per) % 4);
            if (sel_gates(i) !== v) gok = 0;
            n++;
            tick();
        end
        n_total++;
        if (sel_done(i) !== 1'b1)
            $display("FAIL done_pulse inst%0d: got %b want 1",
                     i, sel_done(i));
        else n_pass++;
        n_total++;
        if (!gok)
            $display("FAIL gate_seq inst%0d: got bad want 00,01,10,11",
                     i);
        else n_pass++;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL sb_empty inst%0d: got done want no run", i);
        end else begin
            n_pass++;
            e = sb.pop_front();
            n_total++;
            if (e.inst != i || n != e.busy)
                $display("FAIL busy_len inst%0d: got %0d want %0d",
                         i, n, e.busy);
            else n_pass++;
            n_total++;
            if (sel_err(i) != e.err)
                $display("FAIL err_count inst%0d: got %0d want %0d",
                         i, sel_err(i), e.err);
            else n_pass++;
            n_total++;
            if (sel_pass(i) !== e.pass)
                $display("FAIL pass inst%0d: got %b want %b",
                         i, sel_pass(i), e.pass);
            else n_pass++;
        end
        tick();
        n_total++;
        if (sel_done(i) !== 1'b0 || sel_busy(i) !== 1'b0
            || sel_gates(i) !== 2'b00)
            $display("FAIL idle_after inst%0d: got d%b b%b g%b want 0",
                     i, sel_done(i), sel_busy(i), sel_gates(i));
        else n_pass++;
    endtask

    task automatic run_once(input int i, input int m);
        mode = m;
        sb.push_back(make_exp(i, m));
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        wait_done(i);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_total++;
        if (busy1 !== 0 || done1 !== 0 || pass1 !== 0
            || err1 !== 8'd0 || {a1, b1} !== 2'b00)
            $display("FAIL reset: got b%b d%b p%b e%0d g%b want 0",
                     busy1, done1, pass1, err1, {a1, b1});
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good();
        run_once(1, 0);
    endtask

    task automatic test_stuck0();
        run_once(1, 1);
`ifdef XNOR_BIST_FIRST_FAIL_EN
        n_total++;
        if (fv1 !== 1 || fi1 !== 2'd0 || fy1 !== 0 || fl1 !== 8'd0)
            $display("FAIL first_fail: got v%b i%0d y%b l%0d want 1000",
                     fv1, fi1, fy1, fl1);
        else n_pass++;
`endif
        repeat (5) tick();
        n_total++;
        if (err1 !== 8'd2 || pass1 !== 1'b0)
            $display("FAIL hold_result: got e%0d p%b want e2 p0",
                     err1, pass1);
        else n_pass++;
    endtask

    task automatic test_xor_loops();
        run_once(2, 2);
        run_once(3, 2);
    endtask

    task automatic test_start_held();
        mode = 0;
        sb.push_back(make_exp(1, 0));
        start[1] = 1'b1;
        tick();
        wait_done(1);
        tick();
        n_total++;
        if (busy1 !== 1'b1)
            $display("FAIL held_restart: got busy %b want 1", busy1);
        else n_pass++;
        start[1] = 1'b0;
        sb.push_back(make_exp(1, 0));
        wait_done(1);
    endtask

    task automatic test_abort_start_idle();
        abort = 1'b1;
        start[1] = 1'b1;
        tick();
        abort = 1'b0;
        start[1] = 1'b0;
        n_total++;
        if (busy1 !== 1'b0 || pass1 !== 1'b1)
            $display("FAIL abort_start_idle: got b%b p%b want b0 p1",
                     busy1, pass1);
        else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        bit seen;
        mode = 1;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++;
        if (busy1 !== 0 || done1 !== 0 || pass1 !== 0
            || {a1, b1} !== 2'b00 || err1 !== 8'd1)
            $display("FAIL abort: got b%b d%b p%b g%b e%0d want 0/e1",
                     busy1, done1, pass1, {a1, b1}, err1);
        else n_pass++;
        seen = 0;
        repeat (20) begin
            if (done1 === 1'b1 || busy1 === 1'b1) seen = 1;
            tick();
        end
        n_total++;
        if (seen)
            $display("FAIL abort_quiet: got activity want none");
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        mode = 1;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (busy1 !== 0 || done1 !== 0 || pass1 !== 0
            || err1 !== 8'd0 || {a1, b1} !== 2'b00)
            $display("FAIL rst_mid: got b%b d%b p%b e%0d g%b want 0",
                     busy1, done1, pass1, err1, {a1, b1});
        else n_pass++;
        tick();
        run_once(1, 0);
    endtask

    initial begin
        test_reset();
        test_good();
        test_stuck0();
        test_xor_loops();
        test_start_held();
        test_abort_start_idle();
        test_abort();
        test_rst_mid();
        n_total++;
        if (sb.size() != 0)
            $display("FAIL sb_leftover: got %0d want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
